io_register_bank: RTL

IO_REGISTER_BANK -- requirements
Module: io_register_bank

---
 rtl/io_register_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/io_register_bank.sv
// Processor-visible register bank: RW data registers behind a two-key write lock,
// W1C status registers set by hardware events, an interrupt-enable register and a masked Irq.
module io_register_bank #(
  parameter int unsigned                     DATA_WIDTH  = 32,
  parameter int unsigned                     NUM_REGS    = 4,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]             W1C_MASK    = '0,
  parameter bit                              LOCK_EN     = 1'b1,
  parameter logic [31:0]                     KEY1        = 32'h0000_A5A5,
  parameter logic [31:0]                     KEY2        = 32'h0000_5A5A,
  localparam int unsigned                    ADDR_WIDTH  = $clog2(NUM_REGS + 2)
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Sys_WrEn,
  input  logic                           Sys_RdEn,
  input  logic [ADDR_WIDTH-1:0]          Sys_Address,
  input  logic [DATA_WIDTH-1:0]          Sys_WrData,
  output logic [DATA_WIDTH-1:0]          Sys_RdData,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] Hw_Event,
  output logic [NUM_REGS*DATA_WIDTH-1:0] Reg_Out,
  output logic                           Irq,
  output logic                           Locked
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_KEY = ADDR_WIDTH'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IE  = ADDR_WIDTH'(NUM_REGS + 1);
  localparam logic [DATA_WIDTH-1:0] KEY1_W   = DATA_WIDTH'(KEY1);
  localparam logic [DATA_WIDTH-1:0] KEY2_W   = DATA_WIDTH'(KEY2);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY1_OK  = 2'd1,
    ST_UNLOCKED = 2'd2
  } lock_state_e;

  lock_state_e             state_q, state_d;
  logic                    locked_q, locked_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     ie_q, ie_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    irq_q, irq_d;
  logic [NUM_REGS-1:0]     nonzero_c;
  logic                    key_wr_c;

  assign key_wr_c = Sys_WrEn && (Sys_Address == ADDR_KEY);

  // Lock sequencer: KEY1 then KEY2 back-to-back writes (idle cycles allowed) to the KEY register.
  always_comb begin
    state_d = state_q;
    if (Sys_WrEn) begin
      unique case (state_q)
        ST_LOCKED:   state_d = (key_wr_c && Sys_WrData == KEY1_W) ? ST_KEY1_OK : ST_LOCKED;
        ST_KEY1_OK:  state_d = (key_wr_c && Sys_WrData == KEY2_W) ? ST_UNLOCKED : ST_LOCKED;
        ST_UNLOCKED: state_d = key_wr_c ? ST_LOCKED : ST_UNLOCKED;
        default:     state_d = ST_LOCKED;
      endcase
    end
    if (!LOCK_EN) state_d = ST_UNLOCKED;
    locked_d = (state_d != ST_UNLOCKED);
  end

  // Data registers: W1C slots merge clear and event (event wins); RW slots obey the lock.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (W1C_MASK[i]) begin
        regs_d[i] = (regs_q[i] & ~((Sys_WrEn && Sys_Address == ADDR_WIDTH'(i)) ? Sys_WrData
                                                                              : '0))
                    | Hw_Event[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (Sys_WrEn && Sys_Address == ADDR_WIDTH'(i) && state_q == ST_UNLOCKED) begin
        regs_d[i] = Sys_WrData;
      end
    end
    ie_d = ie_q;
    if (Sys_WrEn && Sys_Address == ADDR_IE) ie_d = Sys_WrData[NUM_REGS-1:0];
  end

  // Read mux samples current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_data_d = rd_data_q;
    if (Sys_RdEn) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (Sys_Address == ADDR_WIDTH'(i)) rd_data_d = regs_q[i];
      end
      if (Sys_Address == ADDR_KEY) rd_data_d = DATA_WIDTH'(locked_q);
      if (Sys_Address == ADDR_IE)  rd_data_d = DATA_WIDTH'(ie_q);
    end
  end

  always_comb begin
    nonzero_c = '0;
    for (int i = 0; i < NUM_REGS; i++) nonzero_c[i] = (regs_q[i] != '0);
    irq_d = |(ie_q & nonzero_c & W1C_MASK);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= LOCK_EN ? ST_LOCKED : ST_UNLOCKED;
      locked_q  <= LOCK_EN;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
      ie_q      <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      locked_q  <= locked_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      ie_q      <= ie_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign Reg_Out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign Sys_RdData = rd_data_q;
  assign Irq        = irq_q;
  assign Locked     = locked_q;

endmodule
